ram_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer for the single-port asynchronous `ram` block (cs/we/oe, tri-state read data). Two synchronous requesters issue read or write transactions over a valid/ready handshake; the arbiter grants one at a time and drives the RAM control pins through a fixed four-state sequence. It returns read data, or a write acknowledge, to the granted requester. It sits between bus-side masters and the RAM in test and co-simulation builds.

---
 rtl/ram_arbiter_if.sv | 33 +++
 rtl/ram_arbiter.sv | 107 ++++++++++
 tb/tb_ram_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  p0_valid, p1_valid;
    logic                  p0_ready, p1_ready;
    logic                  p0_we, p1_we;
    logic [ADDR_WIDTH-1:0] p0_addr, p1_addr;
    logic [DATA_WIDTH-1:0] p0_wdata, p1_wdata;
    logic                  p0_rsp_valid, p1_rsp_valid;
    logic [DATA_WIDTH-1:0] p0_rdata, p1_rdata;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  ram_cs, ram_we, ram_oe;
    logic                  busy;

    modport slave (
        input  p0_valid, p1_valid, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
        input  ram_rdata,
        output p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rdata, p1_rdata,
        output ram_addr, ram_wdata, ram_cs, ram_we, ram_oe, busy
    );

    modport master (
        output p0_valid, p1_valid, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
        output ram_rdata,
        input  p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rdata, p1_rdata,
        input  ram_addr, ram_wdata, ram_cs, ram_we, ram_oe, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter driving an asynchronous single-port RAM through
// a fixed IDLE/SETUP/STROBE/RELEASE sequence.
module ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StRelease} state_e;

    state_e                state_q, state_d;
    logic                  ptr_q, port_q, we_q;
    logic                  grant, accept, grant_we, lat_we;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_wdata;
    logic                  cs_d, we_d, oe_d, rsp0_d, rsp1_d;

    // Pointer only matters when both ports contend.
    always_comb begin
        grant       = (bus.p0_valid && bus.p1_valid) ? ptr_q : bus.p1_valid;
        accept      = (state_q == StIdle) && (bus.p0_valid || bus.p1_valid) && !rst;
        grant_we    = grant ? bus.p1_we : bus.p0_we;
        grant_addr  = grant ? bus.p1_addr : bus.p0_addr;
        grant_wdata = grant ? bus.p1_wdata : bus.p0_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StSetup;
            StSetup:   state_d = StStrobe;
            StStrobe:  state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Strobes are registered, so they are decoded from the state being entered.
    always_comb begin
        bus.p0_ready = accept && !grant;
        bus.p1_ready = accept && grant;
        bus.busy     = (state_q != StIdle);
        lat_we       = accept ? grant_we : we_q;
        cs_d         = 1'b0;
        we_d         = 1'b0;
        oe_d         = 1'b0;
        rsp0_d       = 1'b0;
        rsp1_d       = 1'b0;
        unique case (state_d)
            StSetup: begin
                cs_d = 1'b1;
                oe_d = !lat_we;
            end
            StStrobe: begin
                cs_d = 1'b1;
                we_d = lat_we;
                oe_d = !lat_we;
            end
            StRelease: begin
                rsp0_d = !port_q;
                rsp1_d = port_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q            <= 1'b0;
            port_q           <= 1'b0;
            we_q             <= 1'b0;
            bus.ram_addr     <= '0;
            bus.ram_wdata    <= '0;
            bus.ram_cs       <= 1'b0;
            bus.ram_we       <= 1'b0;
            bus.ram_oe       <= 1'b0;
            bus.p0_rsp_valid <= 1'b0;
            bus.p1_rsp_valid <= 1'b0;
            bus.p0_rdata     <= '0;
            bus.p1_rdata     <= '0;
        end else begin
            bus.ram_cs       <= cs_d;
            bus.ram_we       <= we_d;
            bus.ram_oe       <= oe_d;
            bus.p0_rsp_valid <= rsp0_d;
            bus.p1_rsp_valid <= rsp1_d;
            if (accept) begin
                ptr_q         <= !grant;
                port_q        <= grant;
                we_q          <= grant_we;
                bus.ram_addr  <= grant_addr;
                bus.ram_wdata <= grant_wdata;
            end
            if (state_q == StStrobe && !we_q) begin
                if (port_q) bus.p1_rdata <= bus.ram_rdata;
                else        bus.p0_rdata <= bus.ram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: a transaction-level model of the arbitration
// rules and access timeline, plus a behavioural asynchronous RAM.
module tb_ram_arbiter;
    bit   clk = 1'b0;
    logic rst;

    ram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write on rising we, combinational read while cs && oe.
    bit [7:0] ram_mem [256];
    always @(posedge bus.ram_we) begin
        if (bus.ram_cs) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    end
    assign bus.ram_rdata = (bus.ram_cs && bus.ram_oe) ? ram_mem[bus.ram_addr] : 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: memory contents, pointer, position in the 4-cycle access.
    bit [7:0]   mem_m [256];
    int         ptr_m = 0;
    int         phase_m = 0;
    int         cur_port = 0;
    bit         cur_we = 1'b0;
    logic [7:0] exp_rd = 8'h00;
    logic [7:0] addr_m = 8'h00, wdata_m = 8'h00;
    logic [7:0] last_rd [2];
    int         cyc = 0;
    bit         acc_flag [2];
    int         acc_cyc [2];
    int         n_acc = 0;
    int         first_port = -1;

    // Pending requests per port, held valid until accepted.
    bit         pend [2];
    bit         pwe [2];
    logic [7:0] paddr [2], pwd [2];

    task automatic monitor();
        int g;
        logic [7:0] a;
        cyc++;
        check("we_and_oe", bus.ram_we & bus.ram_oe, 0);
        if (rst) begin
            check("rst_ready0", bus.p0_ready, 0);
            check("rst_ready1", bus.p1_ready, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_strobes", {bus.ram_cs, bus.ram_we, bus.ram_oe}, 0);
            check("rst_rsp", {bus.p0_rsp_valid, bus.p1_rsp_valid}, 0);
            check("rst_rdata", {bus.p0_rdata, bus.p1_rdata}, 0);
            check("rst_ram_bus", {bus.ram_addr, bus.ram_wdata}, 0);
            ptr_m = 0; phase_m = 0; addr_m = 0; wdata_m = 0;
            last_rd[0] = 0; last_rd[1] = 0;
            return;
        end
        check("ram_addr", bus.ram_addr, addr_m);
        check("ram_wdata", bus.ram_wdata, wdata_m);
        check("busy", bus.busy, phase_m != 0);
        check("rsp0", bus.p0_rsp_valid, phase_m == 3 && cur_port == 0);
        check("rsp1", bus.p1_rsp_valid, phase_m == 3 && cur_port == 1);
        if (phase_m == 3 && !cur_we) last_rd[cur_port] = exp_rd;
        check("rdata0", bus.p0_rdata, last_rd[0]);
        check("rdata1", bus.p1_rdata, last_rd[1]);
        case (phase_m)
            0: begin
                if (bus.p0_valid && bus.p1_valid) g = ptr_m;
                else if (bus.p0_valid) g = 0;
                else if (bus.p1_valid) g = 1;
                else g = -1;
                check("ready0", bus.p0_ready, g == 0);
                check("ready1", bus.p1_ready, g == 1);
                check("idle_strobes", {bus.ram_cs, bus.ram_we, bus.ram_oe}, 0);
                if (g >= 0) begin
                    cur_port = g;
                    cur_we  = (g == 1) ? bus.p1_we : bus.p0_we;
                    a       = (g == 1) ? bus.p1_addr : bus.p0_addr;
                    addr_m  = a;
                    wdata_m = (g == 1) ? bus.p1_wdata : bus.p0_wdata;
                    if (cur_we) mem_m[a] = wdata_m;
                    else exp_rd = mem_m[a];
                    ptr_m = 1 - g;
                    phase_m = 1;
                    acc_flag[g] = 1'b1;
                    acc_cyc[g] = cyc;
                    n_acc++;
                    if (first_port < 0) first_port = g;
                end
            end
            1: begin
                check("setup_ready", {bus.p0_ready, bus.p1_ready}, 0);
                check("setup_strobes", {bus.ram_cs, bus.ram_we, bus.ram_oe}, {2'b10, !cur_we});
                phase_m = 2;
            end
            2: begin
                check("strobe_ready", {bus.p0_ready, bus.p1_ready}, 0);
                check("strobe_strobes", {bus.ram_cs, bus.ram_we, bus.ram_oe},
                      {1'b1, cur_we, !cur_we});
                phase_m = 3;
            end
            default: begin
                check("release_ready", {bus.p0_ready, bus.p1_ready}, 0);
                check("release_strobes", {bus.ram_cs, bus.ram_we, bus.ram_oe}, 0);
                phase_m = 0;
            end
        endcase
    endtask

    task automatic drive();
        bus.p0_valid = pend[0];
        bus.p0_we    = pwe[0];
        bus.p0_addr  = pend[0] ? paddr[0] : 8'($urandom);
        bus.p0_wdata = pend[0] ? pwd[0] : 8'($urandom);
        bus.p1_valid = pend[1];
        bus.p1_we    = pwe[1];
        bus.p1_addr  = pend[1] ? paddr[1] : 8'($urandom);
        bus.p1_wdata = pend[1] ? pwd[1] : 8'($urandom);
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int p, input bit we, input logic [7:0] a, input logic [7:0] d);
        pend[p] = 1'b1; pwe[p] = we; paddr[p] = a; pwd[p] = d;
    endtask

    task automatic run_pending(input int budget);
        int n;
        n = 0;
        while (pend[0] || pend[1] || phase_m != 0) begin
            drive();
            cycle();
            for (int p = 0; p < 2; p++) if (acc_flag[p]) begin pend[p] = 0; acc_flag[p] = 0; end
            n++;
            if (n > budget) begin
                check("timeout", 1, 0);
                pend[0] = 0; pend[1] = 0;
                break;
            end
        end
        drive();
    endtask

    initial begin
        int a0, n;
        last_rd[0] = 0; last_rd[1] = 0;
        acc_flag[0] = 0; acc_flag[1] = 0;
        pend[0] = 0; pend[1] = 0;
        rst = 1'b1;
        // Reset held with both ports requesting: no ready, all outputs zero.
        post(0, 1'b0, 8'h00, 8'h00);
        post(1, 1'b0, 8'h01, 8'h00);
        drive();
        #1;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;
        run_pending(30);
        check("first_grant_p0", first_port, 0);

        // Single write then read by p0.
        post(0, 1'b1, 8'h12, 8'hA5);
        run_pending(20);
        post(0, 1'b0, 8'h12, 8'h00);
        run_pending(20);
        check("p0_read_back", last_rd[0], 8'hA5);
        post(1, 1'b0, 8'h12, 8'h00);
        run_pending(20);
        check("p1_read_back", last_rd[1], 8'hA5);

        // Contention: pointer now favours p0.
        post(0, 1'b1, 8'h10, 8'h01);
        post(1, 1'b1, 8'h20, 8'h02);
        run_pending(30);
        check("cont_wr_gap", acc_cyc[1] - acc_cyc[0], 4);
        post(0, 1'b0, 8'h10, 8'h00);
        post(1, 1'b0, 8'h20, 8'h00);
        run_pending(30);
        check("cont_rd_gap", acc_cyc[1] - acc_cyc[0], 4);
        check("cont_rd0", last_rd[0], 8'h01);
        check("cont_rd1", last_rd[1], 8'h02);

        // Random mixed traffic on a small address window to get read hits.
        a0 = n_acc;
        n = 0;
        while (n_acc - a0 < 200 && n < 3000) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 2) != 0)
                    post(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            drive();
            cycle();
            for (int p = 0; p < 2; p++) if (acc_flag[p]) begin pend[p] = 0; acc_flag[p] = 0; end
            n++;
        end
        check("random_count_reached", n_acc - a0 >= 200, 1);
        run_pending(30);

        // Reset landing in the STROBE of a read.
        post(0, 1'b0, 8'h10, 8'h00);
        n = 0;
        while (!acc_flag[0] && n < 10) begin drive(); cycle(); n++; end
        check("rst_test_accept", acc_flag[0], 1);
        acc_flag[0] = 0; pend[0] = 0;
        drive();
        cycle();
        check("in_strobe", {bus.ram_cs, bus.ram_oe}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check("async_cs_drop", bus.ram_cs, 0);
        check("async_oe_drop", bus.ram_oe, 0);
        cycle();
        cycle();
        rst = 1'b0;
        phase_m = 0;
        post(1, 1'b1, 8'h30, 8'h5C);
        run_pending(20);
        post(0, 1'b0, 8'h30, 8'h00);
        run_pending(20);
        check("post_rst_read", last_rd[0], 8'h5C);
        for (int i = 0; i < 3; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
